// File: rtl/seg7_scan_rx.sv
// Multiplexed 7-segment bus receiver: recovers the digit value shown on each scanned position.
// Optional macro SEG7_RX_ACTIVE_LOW_EN inverts seg_in/sel_in for common-anode drivers.
module seg7_scan_rx #(
  parameter int NUM_DIGITS    = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int STABLE_SCANS  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   sel_in,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   valid_out,
  output logic [NUM_DIGITS-1:0]   blank_out,
  output logic                    update_o,
  output logic                    err_sel
);

  typedef enum logic [1:0] {
    CLS_ILLEGAL = 2'd0,
    CLS_LEGAL   = 2'd1,
    CLS_BLANK   = 2'd2
  } cls_t;

  typedef struct packed {
    cls_t       cls;
    logic [3:0] val;
  } smp_t;

  localparam int               CW       = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0]    SETTLE_N = CW'(SETTLE_CYCLES);
  localparam logic [3:0]       STABLE_N = 4'(STABLE_SCANS);

  // Pattern 1011110 is shared by codes 10 and 13 on the encoder side; it resolves to 13.
  function automatic smp_t seg_decode(input logic [6:0] p);
    smp_t r;
    r.cls = CLS_LEGAL;
    r.val = 4'd0;
    case (p)
      7'b0111111: r.val = 4'd0;
      7'b0000110: r.val = 4'd1;
      7'b1011011: r.val = 4'd2;
      7'b1001111: r.val = 4'd3;
      7'b1100110: r.val = 4'd4;
      7'b1101101: r.val = 4'd5;
      7'b1111101: r.val = 4'd6;
      7'b0000111: r.val = 4'd7;
      7'b1111111: r.val = 4'd8;
      7'b1101111: r.val = 4'd9;
      7'b0111001: r.val = 4'd11;
      7'b1110110: r.val = 4'd12;
      7'b1011110: r.val = 4'd13;
      7'b1111011: r.val = 4'd14;
      7'b1111110: r.val = 4'd15;
      7'b0000000: r.cls = CLS_BLANK;
      default:    r.cls = CLS_ILLEGAL;
    endcase
    return r;
  endfunction

  function automatic logic [CW-1:0] settle_inc(input logic [CW-1:0] c);
    return (c == SETTLE_N) ? c : c + 1'b1;
  endfunction

  function automatic logic [3:0] scan_inc(input logic [3:0] c);
    return (c >= STABLE_N) ? STABLE_N : c + 4'd1;
  endfunction

  logic [6:0]            seg_raw;
  logic [NUM_DIGITS-1:0] sel_raw;

`ifdef SEG7_RX_ACTIVE_LOW_EN
  assign seg_raw = ~seg_in;
  assign sel_raw = ~sel_in;
`else
  assign seg_raw = seg_in;
  assign sel_raw = sel_in;
`endif

  // Stage p0/s: two-flop synchroniser; p2: previous-cycle copy for change detection
  logic [6:0]            seg_p0, seg_s, seg_p2;
  logic [NUM_DIGITS-1:0] sel_p0, sel_s, sel_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_p0 <= '0;
      seg_s  <= '0;
      seg_p2 <= '0;
      sel_p0 <= '0;
      sel_s  <= '0;
      sel_p2 <= '0;
    end else begin
      seg_p0 <= seg_raw;
      seg_s  <= seg_p0;
      seg_p2 <= seg_s;
      sel_p0 <= sel_raw;
      sel_s  <= sel_p0;
      sel_p2 <= sel_s;
    end
  end

  logic          chg;
  logic [CW-1:0] settle_cnt;
  logic          sampled;
  logic          smp_ev;

  assign chg    = (seg_s != seg_p2) || (sel_s != sel_p2);
  // seg_p2 still holds the settled value even on the cycle a new window arrives
  assign smp_ev = (settle_cnt == SETTLE_N) && !sampled;

  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= '0;
      sampled    <= 1'b0;
    end else if (chg) begin
      settle_cnt <= '0;
      sampled    <= 1'b0;
    end else begin
      settle_cnt <= settle_inc(settle_cnt);
      if (smp_ev) sampled <= 1'b1;
    end
  end

  logic onehot, multi;
  smp_t dec;

  assign onehot = (sel_p2 != '0) && ((sel_p2 & (sel_p2 - 1'b1)) == '0);
  assign multi  = (sel_p2 != '0) && !onehot;
  assign dec    = seg_decode(seg_p2);

  smp_t                  cand [NUM_DIGITS];
  logic [3:0]            mcnt [NUM_DIGITS];
  logic                  match [NUM_DIGITS];
  logic [3:0]            cnt_n [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] hit, commit_n;

  always_comb begin
    hit      = '0;
    commit_n = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      match[i]    = (cand[i] == dec);
      cnt_n[i]    = match[i] ? scan_inc(mcnt[i]) : 4'd1;
      hit[i]      = smp_ev && onehot && sel_p2[i];
      commit_n[i] = hit[i] && (cnt_n[i] == STABLE_N) &&
                    (!match[i] || (mcnt[i] != STABLE_N));
    end
  end

  // Stage p3: per-digit stability filter and committed outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        cand[i] <= '0;
        mcnt[i] <= '0;
      end
      digits_out <= '0;
      valid_out  <= '0;
      blank_out  <= '0;
      update_o   <= 1'b0;
      err_sel    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (hit[i]) begin
          mcnt[i] <= cnt_n[i];
          if (!match[i]) cand[i] <= dec;
        end
        if (commit_n[i]) begin
          valid_out[i] <= (dec.cls == CLS_LEGAL);
          blank_out[i] <= (dec.cls == CLS_BLANK);
          if (dec.cls == CLS_LEGAL) digits_out[4*i +: 4] <= dec.val;
        end
      end
      update_o <= |commit_n;
      err_sel  <= smp_ev && multi;
    end
  end

endmodule

// File: tb/tb_seg7_scan_rx.sv
// Bench for seg7_scan_rx: directed scan sequences plus random windows against a window-level model.
module tb_seg7_scan_rx;

  localparam int ND     = 4;
  localparam int SETTLE = 4;
  localparam int STABLE = 2;
  localparam int DLY    = SETTLE + 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg_in = '0;
  logic [3:0]  sel_in = '0;
  logic [15:0] digits_out;
  logic [3:0]  valid_out, blank_out;
  logic        update_o, err_sel;

  seg7_scan_rx #(.NUM_DIGITS(ND), .SETTLE_CYCLES(SETTLE), .STABLE_SCANS(STABLE)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .sel_in(sel_in),
    .digits_out(digits_out), .valid_out(valid_out), .blank_out(blank_out),
    .update_o(update_o), .err_sel(err_sel)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int upd_seen = 0;
  int err_seen = 0;

  logic [6:0] enc [16];

  // Model: class 0 = legal, 1 = blank, 2 = illegal, -1 = no candidate yet
  int         cand_cls [ND];
  logic [3:0] cand_val [ND];
  int         cand_cnt [ND];
  logic [3:0] m_dig [ND];
  logic [3:0] m_vld, m_blk;

  typedef struct {
    int         t;
    bit         is_err;
    int         d;
    int         cls;
    logic [3:0] val;
  } ev_t;
  ev_t evq[$];

  logic [6:0] last_seg;
  logic [3:0] last_sel;
  int         runlen, run_start;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ND; i++) begin
      cand_cls[i] = -1;
      cand_val[i] = 4'd0;
      cand_cnt[i] = 0;
      m_dig[i]    = 4'd0;
    end
    m_vld  = '0;
    m_blk  = '0;
    evq.delete();
    runlen = 0;
  endtask

  task automatic model_sample(input logic [6:0] s, input logic [3:0] sl, input int t);
    int ones, d, cls, old;
    logic [3:0] v;
    bit same;
    ones = $countones(sl);
    if (ones == 0) return;
    if (ones > 1) begin
      evq.push_back('{t: t, is_err: 1'b1, d: 0, cls: 0, val: 4'd0});
      return;
    end
    d = 0;
    for (int i = 0; i < ND; i++) if (sl[i]) d = i;
    cls = 2;
    v   = 4'd0;
    if (s == 7'd0) cls = 1;
    else for (int c = 0; c < 16; c++) if (enc[c] == s) begin cls = 0; v = 4'(c); end
    same = (cand_cls[d] == cls) && (cand_val[d] == v);
    old  = cand_cnt[d];
    if (same) cand_cnt[d] = (old < STABLE) ? old + 1 : STABLE;
    else begin
      cand_cls[d] = cls;
      cand_val[d] = v;
      cand_cnt[d] = 1;
    end
    if (cand_cnt[d] == STABLE && (!same || old < STABLE))
      evq.push_back('{t: t, is_err: 1'b0, d: d, cls: cls, val: v});
  endtask

  task automatic step(input logic r, input logic [6:0] s, input logic [3:0] sl);
    bit eu, ee;
    ev_t ev;
    logic [15:0] dig;
    @(negedge clk);
    eu = 1'b0;
    ee = 1'b0;
    while (evq.size() > 0 && evq[0].t == cyc) begin
      ev = evq.pop_front();
      if (ev.is_err) ee = 1'b1;
      else begin
        eu = 1'b1;
        m_vld[ev.d] = (ev.cls == 0);
        m_blk[ev.d] = (ev.cls == 1);
        if (ev.cls == 0) m_dig[ev.d] = ev.val;
      end
    end
    dig = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
    chk("digits_out", digits_out, dig);
    chk("valid_out", 16'(valid_out), 16'(m_vld));
    chk("blank_out", 16'(blank_out), 16'(m_blk));
    chk("update_o", 16'(update_o), 16'(eu));
    chk("err_sel", 16'(err_sel), 16'(ee));
    if (update_o === 1'b1) upd_seen++;
    if (err_sel === 1'b1) err_seen++;
    rst = r;
`ifdef SEG7_RX_ACTIVE_LOW_EN
    seg_in = ~s;
    sel_in = ~sl;
`else
    seg_in = s;
    sel_in = sl;
`endif
    if (r) model_reset();
    else begin
      if (runlen == 0 || s != last_seg || sl != last_sel) begin
        runlen    = 1;
        run_start = cyc;
      end else runlen++;
      last_seg = s;
      last_sel = sl;
      if (runlen == SETTLE + 1) model_sample(s, sl, run_start + DLY);
    end
    cyc++;
  endtask

  task automatic win(input logic [6:0] s, input logic [3:0] sl, input int n);
    repeat (n) step(1'b0, s, sl);
  endtask

  logic [6:0] p4 [4];
  logic [6:0] shown [4];
  int lens [7];

  initial begin
    enc[0]  = 7'b0111111; enc[1]  = 7'b0000110; enc[2]  = 7'b1011011; enc[3]  = 7'b1001111;
    enc[4]  = 7'b1100110; enc[5]  = 7'b1101101; enc[6]  = 7'b1111101; enc[7]  = 7'b0000111;
    enc[8]  = 7'b1111111; enc[9]  = 7'b1101111; enc[10] = 7'b1011110; enc[11] = 7'b0111001;
    enc[12] = 7'b1110110; enc[13] = 7'b1011110; enc[14] = 7'b1111011; enc[15] = 7'b1111110;
    lens = '{2, 3, 6, 7, 8, 9, 10};
    model_reset();

    repeat (3) step(1'b1, 7'd0, 4'd0);
    chk("reset_digits", digits_out, 16'h0000);

    // Idle bus
    upd_seen = 0;
    err_seen = 0;
    win(7'd0, 4'd0, 100);
    chk("idle_updates", 16'(upd_seen), 16'd0);
    chk("idle_errs", 16'(err_seen), 16'd0);

    // Two full scans of 1,2,3,4
    p4 = '{7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110};
    upd_seen = 0;
    for (int sc = 0; sc < 2; sc++)
      for (int d = 0; d < 4; d++) win(p4[d], 4'(1 << d), 8);
    win(7'd0, 4'd0, 16);
    chk("scan_digits", digits_out, 16'h4321);
    chk("scan_valid", 16'(valid_out), 16'h000F);
    chk("scan_updates", 16'(upd_seen), 16'd4);

    // Too-short window
    win(7'b1111111, 4'b0001, 3);
    win(7'd0, 4'd0, 16);
    chk("short_window", digits_out, 16'h4321);

    // Digit 2 alternating between 9 and 8 never settles
    for (int sc = 0; sc < 4; sc++)
      for (int d = 0; d < 4; d++)
        if (d == 2) win((sc % 2 == 0) ? 7'b1101111 : 7'b1111111, 4'b0100, 8);
        else win(p4[d], 4'(1 << d), 8);
    win(7'd0, 4'd0, 16);
    chk("alternating", digits_out, 16'h4321);

    // Shared pattern resolves to 13
    win(7'b1011110, 4'b0010, 8);
    win(7'd0, 4'd0, 8);
    win(7'b1011110, 4'b0010, 8);
    win(7'd0, 4'd0, 16);
    chk("shared_pattern", digits_out, 16'h43D1);

    // Blank on digit 1
    win(7'd0, 4'b0010, 8);
    win(7'd0, 4'd0, 8);
    win(7'd0, 4'b0010, 8);
    win(7'd0, 4'd0, 16);
    chk("blank_digits", digits_out, 16'h43D1);
    chk("blank_valid", 16'(valid_out), 16'h000D);
    chk("blank_flag", 16'(blank_out), 16'h0002);

    // Multi-hot select
    err_seen = 0;
    win(7'b0000110, 4'b0101, 8);
    win(7'd0, 4'd0, 16);
    chk("multi_hot_err", 16'(err_seen), 16'd1);
    chk("multi_hot_digits", digits_out, 16'h43D1);

    // Reset during the second scan, then one scan only
    p4 = '{7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111};
    for (int d = 0; d < 4; d++) win(p4[d], 4'(1 << d), 8);
    win(p4[0], 4'b0001, 8);
    win(p4[1], 4'b0010, 4);
    repeat (3) step(1'b1, p4[1], 4'b0010);
    for (int d = 0; d < 4; d++) win(p4[d], 4'(1 << d), 8);
    win(7'd0, 4'd0, 16);
    chk("post_reset_digits", digits_out, 16'h0000);
    chk("post_reset_valid", 16'(valid_out), 16'h0000);

    // Random windows
    for (int d = 0; d < 4; d++) shown[d] = enc[$urandom_range(0, 15)];
    for (int w = 0; w < 120; w++) begin
      int kind, len, d;
      logic [3:0] sl;
      kind = $urandom_range(0, 9);
      len  = lens[$urandom_range(0, 6)];
      d    = w % 4;
      if (kind == 0) win(7'd0, 4'd0, len);
      else if (kind == 1) begin
        sl = 4'($urandom_range(0, 15));
        while ($countones(sl) < 2) sl = 4'($urandom_range(0, 15));
        win(7'($urandom_range(0, 127)), sl, len);
      end else begin
        if ($urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 5))
            0:       shown[d] = 7'd0;
            1:       shown[d] = 7'($urandom_range(0, 127));
            default: shown[d] = enc[$urandom_range(0, 15)];
          endcase
        end
        win(shown[d], 4'(1 << d), len);
      end
    end
    win(7'd0, 4'd0, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
